dm_access_ctrl: RTL and testbench
=================================

Name: dm_access_ctrl

Overview:
Sequencer between the MEM pipeline stage and a word-wide synchronous data SRAM. Accepts one load/store per handshake, decodes the MIPS opcode, and performs sub-word stores as read-modify-write because the SRAM has no byte strobes. Extracts and sign- or zero-extends load data, and flags misaligned or unknown accesses. Holds the pipeline through req_ready until each access completes.

Parameters:
ADDR_W, 32, byte-address width of req_addr; mem_addr is ADDR_W-2 bits (word address)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  MEM stage presents an access
req_ready  output  1  controller can accept; high only in IDLE
req_op  input  6  MIPS opcode: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100, sw 101011, sh 101001, sb 101000
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-aligned (sb uses [7:0], sh uses [15:0])
resp_valid  output  1  one-cycle pulse when the access completes
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  valid with resp_valid: misaligned access or unknown op
mem_en  output  1  SRAM access strobe
mem_we  output  1  SRAM write, qualified by mem_en
mem_addr  output  ADDR_W-2  SRAM word address, req_addr[ADDR_W-1:2]
mem_wdata  output  32  SRAM write word
mem_rdata  input  32  SRAM read word, valid the cycle after mem_en=1 with mem_we=0

Behaviour:
- Reset (async, active-high) forces state IDLE. All outputs are 0 except req_ready=1. An in-flight access is abandoned, with no write and no response. Outputs are decoded from registered state, so mem_we drops the moment reset asserts.
- States: IDLE, WR, RD, MERGE, LDRET, ERR.
- IDLE: req_ready=1. On req_valid, latch op, addr and wdata, then branch by op:
  - Misaligned access goes to ERR. Misaligned means sw/lw with addr[1:0]!=0, or sh/lh/lhu with addr[0]=1. Unknown op also goes to ERR.
  - sw goes to WR.
  - sb and sh go to RD, then MERGE.
  - Loads go to RD, then LDRET.
- Request fields are sampled only on the accept cycle. req_valid while busy is ignored; the requester holds it.
- Accept in cycle T gives this timing:
  - sw: WR in T+1 with mem_en=1, mem_we=1, mem_wdata=wdata. resp_valid in T+1.
  - sb/sh: RD in T+1 with mem_en=1, mem_we=0. MERGE in T+2 writes the merged word (mem_en=1, mem_we=1) and pulses resp_valid.
  - Loads: RD in T+1. LDRET in T+2 pulses resp_valid with extended data.
  - Error: ERR in T+1 pulses resp_valid and resp_err=1, with no SRAM access.
- Every terminal state returns to IDLE the next cycle, so the earliest back-to-back accept is at T+2 for sw and T+3 for sub-word accesses and loads.
- Lane mapping is little-endian: byte k = bits [8k+7:8k] at addr[1:0]=k; halfword h = bits [16h+15:16h] at addr[1]=h.
- Merge: take mem_rdata and replace the addressed lane or half with wdata[7:0] or wdata[15:0]. All other bits are preserved.
- Load extension: lb/lh sign-extend from bit 7/15 of the selected lane; lbu/lhu zero-extend; lw passes the word through.
- mem_addr and mem_wdata are 0 whenever mem_en=0.

Optional Feature:
DM_BYTE_STROBE_EN.
- Defined: adds output port mem_be[3:0], valid with mem_en&mem_we.
  - sw drives 1111. sh drives 0011 or 1100 by addr[1]. sb drives 0001, 0010, 0100 or 1000 by addr[1:0].
  - sb and sh go IDLE→WR directly, with mem_wdata set to the store data replicated into the target lane. No RMW.
  - MERGE is unreachable.
- Not defined: no mem_be port; sub-word stores use RD→MERGE as above.

Test Plan:
- sw, addr 0x10, wdata 0xDEADBEEF → WR in T+1: mem_addr 0x4, mem_we=1, mem_wdata 0xDEADBEEF; resp_valid T+1, resp_err=0.
- SRAM word 0x4 = 0x11223344; sb addr 0x12, wdata 0x000000AA → RD T+1, MERGE T+2 writes 0x11AA3344.
- SRAM word 0x4 = 0x80FF7F01:
  - lb 0x13 → resp_rdata 0xFFFFFF80 at T+2.
  - lbu 0x13 → 0x00000080.
  - lh 0x12 → 0xFFFF80FF.
  - lhu 0x10 → 0x00007F01.
- sh addr 0x11 → ERR in T+1: resp_valid=1, resp_err=1, mem_en stays 0. Also op 0x3F at addr 0x0 → resp_err=1.
- Reset asserted during MERGE of sb → mem_we falls immediately, SRAM word unchanged, no resp_valid, req_ready=1 after reset.
- With DM_BYTE_STROBE_EN: sh addr 0x12, wdata 0x0000BEEF → single WR in T+1, mem_be 1100, mem_wdata[31:16]=0xBEEF, resp_valid T+1.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - MEM-stage to word-wide SRAM load/store sequencer
//
// Ports:
//   clk, reset               clock, async active-high reset
//   req_valid/req_ready      one access per handshake; ready only when idle
//   req_op/req_addr/req_wdata MIPS opcode, byte address, right-aligned store data
//   resp_valid/resp_rdata/resp_err  completion pulse, extended load data, error flag
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  synchronous SRAM, 1-cycle read latency
//   mem_be                   byte strobes (only with DM_BYTE_STROBE_EN)
//
// Option: DM_BYTE_STROBE_EN - SRAM has byte strobes, so sub-word stores are
// single writes instead of read-modify-write.

module dm_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef DM_BYTE_STROBE_EN
    ,
    output logic [3:0]        mem_be
`endif
);

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD, S_MERGE, S_LDRET, S_ERR
    } state_t;

    // Sub-word stores: direct write with strobes, otherwise read first and merge.
`ifdef DM_BYTE_STROBE_EN
    localparam state_t SUBW_ST = S_WR;
`else
    localparam state_t SUBW_ST = S_RD;
`endif

    state_t            state, state_nxt;
    logic [5:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            op_q    <= 6'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && req_valid) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Decode straight from the request bus in IDLE; the latched copy is only
    // available from the following cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_SW:          state_nxt = (req_addr[1:0] != 2'b00) ? S_ERR : S_WR;
                        OP_LW:          state_nxt = (req_addr[1:0] != 2'b00) ? S_ERR : S_RD;
                        OP_SH:          state_nxt = req_addr[0] ? S_ERR : SUBW_ST;
                        OP_LH, OP_LHU:  state_nxt = req_addr[0] ? S_ERR : S_RD;
                        OP_SB:          state_nxt = SUBW_ST;
                        OP_LB, OP_LBU:  state_nxt = S_RD;
                        default:        state_nxt = S_ERR;
                    endcase
                end
            end
            S_RD:    state_nxt = (op_q == OP_SB || op_q == OP_SH) ? S_MERGE : S_LDRET;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Lane selection shared by merge and load extension.
    logic [4:0]  bshift;
    logic [31:0] rd_shift;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged;
    logic [31:0] load_ext;
    logic [15:0] ld_half;

    always_comb begin
        bshift    = {addr_q[1:0], 3'b000};
        rd_shift  = mem_rdata >> bshift;
        ld_half   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        if (op_q == OP_SH) begin
            lane_mask = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            lane_data = {2{wdata_q[15:0]}};
        end else begin
            lane_mask = 32'h0000_00FF << bshift;
            lane_data = {4{wdata_q[7:0]}};
        end
        merged = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);
        case (op_q)
            OP_LB:   load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            OP_LBU:  load_ext = {24'd0, rd_shift[7:0]};
            OP_LH:   load_ext = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  load_ext = {16'd0, ld_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Outputs depend only on registered state so reset clears them at once.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 32'd0;
`ifdef DM_BYTE_STROBE_EN
        mem_be     = 4'b0000;
`endif
        case (state)
            S_IDLE: req_ready = 1'b1;
            S_WR: begin
                mem_en     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = addr_q[ADDR_W-1:2];
                resp_valid = 1'b1;
`ifdef DM_BYTE_STROBE_EN
                if (op_q == OP_SW) begin
                    mem_wdata = wdata_q;
                    mem_be    = 4'b1111;
                end else if (op_q == OP_SH) begin
                    mem_wdata = lane_data;
                    mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                end else begin
                    mem_wdata = lane_data;
                    mem_be    = 4'b0001 << addr_q[1:0];
                end
`else
                mem_wdata  = wdata_q;
`endif
            end
            S_RD: begin
                mem_en   = 1'b1;
                mem_addr = addr_q[ADDR_W-1:2];
            end
            S_MERGE: begin
                mem_en     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = addr_q[ADDR_W-1:2];
                mem_wdata  = merged;
                resp_valid = 1'b1;
            end
            S_LDRET: begin
                resp_valid = 1'b1;
                resp_rdata = load_ext;
            end
            S_ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb/tb_dm_access_ctrl.sv - scoreboard bench for dm_access_ctrl

module tb_dm_access_ctrl;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;
`ifdef DM_BYTE_STROBE_EN
    localparam int SUBW_LAT = 1;
`else
    localparam int SUBW_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_op = 6'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
`ifdef DM_BYTE_STROBE_EN
    logic [3:0]  mem_be;
`endif

    dm_access_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DM_BYTE_STROBE_EN
        , .mem_be(mem_be)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int en_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: one-cycle read latency, writes at the clock edge.
    logic [31:0] sram [logic [29:0]];
    always @(posedge clk) begin
        if (mem_en) begin
            en_cnt++;
            if (mem_we) begin
`ifdef DM_BYTE_STROBE_EN
                logic [31:0] w;
                w = sram.exists(mem_addr) ? sram[mem_addr] : 32'd0;
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                sram[mem_addr] = w;
`else
                sram[mem_addr] = mem_wdata;
`endif
            end else begin
                mem_rdata <= sram.exists(mem_addr) ? sram[mem_addr] : 32'd0;
            end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t q[$];

    always @(negedge clk) begin
        if (resp_valid) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_resp rdata=%h err=%b want no response", resp_rdata, resp_err);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (resp_rdata !== e.rdata || resp_err !== e.err || cyc !== e.cyc) begin
                    bad++;
                    $display("FAIL resp got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                             resp_rdata, resp_err, cyc, e.rdata, e.err, e.cyc);
                end
            end
        end
    end

    // Present a request from a negedge, wait for acceptance, expect the
    // response lat cycles after the accept cycle. Returns at the negedge of T+1.
    task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata_exp, input logic err_exp, input int lat,
                         output int acc);
        int n;
        exp_t e;
        n = 0;
        req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!req_ready) begin
            bad++;
            $display("FAIL accept_timeout ready=%b want 1", req_ready);
            req_valid = 1'b0;
            acc = cyc;
            return;
        end
        e.rdata = rdata_exp; e.err = err_exp; e.cyc = cyc + lat;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL resp_timeout pending=%0d want 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0 ||
            mem_addr !== 30'd0 || mem_wdata !== 32'd0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs ready=%b rv=%b en=%b we=%b want ready=1 others 0",
                     req_ready, resp_valid, mem_en, mem_we);
        end
        reset = 1'b0;
    endtask

    task automatic test_sw();
        int acc;
        issue(OP_SW, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 1, acc);
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 30'h4 ||
            mem_wdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL sw_write en=%b we=%b addr=%h wdata=%h ready=%b want 1 1 4 deadbeef 0",
                     mem_en, mem_we, mem_addr, mem_wdata, req_ready);
        end
        drain();
        total++;
        if (sram[30'h4] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL sw_sram got=%h want=deadbeef", sram[30'h4]);
        end
    endtask

    task automatic test_subword_store();
        int acc, e0;
        sram[30'h4] = 32'h11223344;
        e0 = en_cnt;
        issue(OP_SB, 32'h12, 32'h000000AA, 32'd0, 1'b0, SUBW_LAT, acc);
        total++;
`ifdef DM_BYTE_STROBE_EN
        if (mem_we !== 1'b1 || mem_be !== 4'b0100 || mem_wdata[23:16] !== 8'hAA) begin
            bad++;
            $display("FAIL sb_strobe we=%b be=%b wdata=%h want 1 0100 lane2=aa", mem_we, mem_be, mem_wdata);
        end
`else
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 30'h4 || mem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL sb_read en=%b we=%b addr=%h wdata=%h want 1 0 4 0", mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h11AA3344) begin
            bad++;
            $display("FAIL sb_merge en=%b we=%b wdata=%h want 1 1 11aa3344", mem_en, mem_we, mem_wdata);
        end
`endif
        drain();
        total++;
        if (sram[30'h4] !== 32'h11AA3344 || en_cnt - e0 !== SUBW_LAT) begin
            bad++;
            $display("FAIL sb_sram got=%h accesses=%0d want=11aa3344 %0d", sram[30'h4], en_cnt - e0, SUBW_LAT);
        end
        e0 = en_cnt;
        issue(OP_SH, 32'h12, 32'h0000BEEF, 32'd0, 1'b0, SUBW_LAT, acc);
`ifdef DM_BYTE_STROBE_EN
        total++;
        if (mem_we !== 1'b1 || mem_be !== 4'b1100 || mem_wdata[31:16] !== 16'hBEEF || resp_valid !== 1'b1) begin
            bad++;
            $display("FAIL sh_strobe we=%b be=%b wdata=%h rv=%b want 1 1100 beef.... 1",
                     mem_we, mem_be, mem_wdata, resp_valid);
        end
`endif
        drain();
        total++;
        if (sram[30'h4] !== 32'hBEEF3344 || en_cnt - e0 !== SUBW_LAT) begin
            bad++;
            $display("FAIL sh_sram got=%h accesses=%0d want=beef3344 %0d", sram[30'h4], en_cnt - e0, SUBW_LAT);
        end
    endtask

    task automatic test_loads();
        logic [5:0]  ops [6]  = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LB};
        logic [31:0] adrs [6] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h11};
        logic [31:0] exps [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                                  32'h00007F01, 32'h80FF7F01, 32'h0000007F};
        int acc;
        sram[30'h4] = 32'h80FF7F01;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], adrs[i], 32'hFFFFFFFF, exps[i], 1'b0, 2, acc);
            total++;
            if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 30'h4) begin
                bad++;
                $display("FAIL load_read[%0d] en=%b we=%b addr=%h want 1 0 4", i, mem_en, mem_we, mem_addr);
            end
            drain();
        end
    endtask

    task automatic test_errors();
        logic [5:0]  ops [4]  = '{OP_SH, 6'h3F, OP_LW, OP_LHU};
        logic [31:0] adrs [4] = '{32'h11, 32'h0, 32'h12, 32'h13};
        int acc, e0;
        for (int i = 0; i < 4; i++) begin
            e0 = en_cnt;
            issue(ops[i], adrs[i], 32'h12345678, 32'd0, 1'b1, 1, acc);
            drain();
            total++;
            if (en_cnt != e0) begin
                bad++;
                $display("FAIL err_no_access[%0d] accesses=%0d want 0", i, en_cnt - e0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int a0, a1, a2, a3;
        issue(OP_SW, 32'h20, 32'h11111111, 32'd0, 1'b0, 1, a0);
        issue(OP_SW, 32'h24, 32'h22222222, 32'd0, 1'b0, 1, a1);
        issue(OP_LW, 32'h20, 32'd0, 32'h11111111, 1'b0, 2, a2);
        issue(OP_LBU, 32'h24, 32'd0, 32'h00000022, 1'b0, 2, a3);
        drain();
        total++;
        if (a1 - a0 !== 2 || a2 - a1 !== 2 || a3 - a2 !== 3) begin
            bad++;
            $display("FAIL b2b_spacing got=%0d,%0d,%0d want=2,2,3", a1 - a0, a2 - a1, a3 - a2);
        end
    endtask

    task automatic test_reset_in_merge();
        int acc;
        sram[30'h8] = 32'h55667788;
        issue(OP_SB, 32'h21, 32'h000000CC, 32'd0, 1'b0, SUBW_LAT, acc);
`ifndef DM_BYTE_STROBE_EN
        @(posedge clk);
        #2;
        total++;
        if (mem_we !== 1'b1) begin
            bad++;
            $display("FAIL merge_before_reset we=%b want 1", mem_we);
        end
        reset = 1'b1;
        #1;
        q.delete();
        total++;
        if (mem_we !== 1'b0 || mem_en !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_merge we=%b en=%b rv=%b ready=%b want 0 0 0 1",
                     mem_we, mem_en, resp_valid, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (sram[30'h8] !== 32'h55667788 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_sram got=%h ready=%b want=55667788 1", sram[30'h8], req_ready);
        end
`else
        drain();
        total++;
        if (sram[30'h8] !== 32'h5566CC88) begin
            bad++;
            $display("FAIL sb_lane1 got=%h want=5566cc88", sram[30'h8]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_sw();
        test_subword_store();
        test_loads();
        test_errors();
        test_back_to_back();
        test_reset_in_merge();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
